// File: rtl/branch_update_queue_if.sv
// Fetch/execute/commit side bundle of the branch update queue.
// "master" is the pipeline side; "slave" is the queue itself.
interface branch_update_queue_if #(
  parameter int IDX_W = 10,
  parameter int TAG_W = 4
);
  logic             alloc_valid;
  logic [IDX_W-1:0] alloc_index;
  logic             alloc_pred;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             resolve_taken;
  logic             commit_valid;
  logic             flush;
  logic             update_valid;
  logic             update_value;
  logic [IDX_W-1:0] index_write;
  logic             mispredict;
  logic [TAG_W-1:0] mispredict_tag;
  logic             commit_err;
  logic [TAG_W:0]   count;

  modport master (
    output alloc_valid, alloc_index, alloc_pred, resolve_valid, resolve_tag,
           resolve_taken, commit_valid, flush,
    input  alloc_ready, alloc_tag, update_valid, update_value, index_write,
           mispredict, mispredict_tag, commit_err, count
  );

  modport slave (
    input  alloc_valid, alloc_index, alloc_pred, resolve_valid, resolve_tag,
           resolve_taken, commit_valid, flush,
    output alloc_ready, alloc_tag, update_valid, update_value, index_write,
           mispredict, mispredict_tag, commit_err, count
  );
endinterface

// File: rtl/branch_update_queue.sv
// In-order retirement queue for predicted branches: allocate at fetch, resolve
// out of order at execute, train the BPB exactly once per committed branch.
module branch_update_queue #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_update_queue_if.slave  bus
);
  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]            valid_q, valid_d, resolved_q, resolved_d;
  logic [DEPTH-1:0]            pred_q, pred_d, taken_q, taken_d;
  logic [DEPTH-1:0][IDX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]            head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]              count_q, count_d;
  logic                        upd_v_q, upd_v_d, upd_val_q, upd_val_d;
  logic [IDX_W-1:0]            upd_idx_q, upd_idx_d;
  logic                        mis_q, mis_d, cerr_q, cerr_d;
  logic [TAG_W-1:0]            mis_tag_q, mis_tag_d;

  logic alloc_ready, alloc_fire, res_ok, res_fire, head_ok, commit_fire;

  // Readiness looks only at the registered count, so a commit never frees a slot
  // for an allocate in the same cycle.
  assign alloc_ready = (count_q != FULL);

  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    pred_d     = pred_q;
    taken_d    = taken_q;
    index_d    = index_q;
    head_d     = head_q;
    tail_d     = tail_q;
    upd_v_d    = 1'b0;
    upd_val_d  = upd_val_q;
    upd_idx_d  = upd_idx_q;
    mis_d      = 1'b0;
    mis_tag_d  = mis_tag_q;

    alloc_fire  = bus.alloc_valid && alloc_ready && !bus.flush;
    res_ok      = bus.resolve_valid && valid_q[bus.resolve_tag] && !resolved_q[bus.resolve_tag];
    res_fire    = res_ok && !bus.flush;
    head_ok     = valid_q[head_q] &&
                  (resolved_q[head_q] || (res_ok && (bus.resolve_tag == head_q)));
    commit_fire = bus.commit_valid && head_ok;
    cerr_d      = bus.commit_valid && !head_ok;

    if (res_fire) begin
      resolved_d[bus.resolve_tag] = 1'b1;
      taken_d[bus.resolve_tag]    = bus.resolve_taken;
      mis_d                       = (bus.resolve_taken != pred_q[bus.resolve_tag]);
      mis_tag_d                   = bus.resolve_tag;
    end

    // An unresolved head can only commit via a same-cycle resolve, so take the
    // outcome straight from the resolve port in that case.
    if (commit_fire) begin
      upd_v_d            = 1'b1;
      upd_val_d          = resolved_q[head_q] ? taken_q[head_q] : bus.resolve_taken;
      upd_idx_d          = index_q[head_q];
      valid_d[head_q]    = 1'b0;
      resolved_d[head_q] = 1'b0;
      head_d             = head_q + 1'b1;
    end

    if (alloc_fire) begin
      valid_d[tail_q]    = 1'b1;
      resolved_d[tail_q] = 1'b0;
      pred_d[tail_q]     = bus.alloc_pred;
      index_d[tail_q]    = bus.alloc_index;
      tail_d             = tail_q + 1'b1;
    end

    count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);

    if (bus.flush) begin
      valid_d    = '0;
      resolved_d = '0;
      head_d     = tail_q;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      resolved_q <= '0;
      pred_q     <= '0;
      taken_q    <= '0;
      index_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      upd_v_q    <= 1'b0;
      upd_val_q  <= 1'b0;
      upd_idx_q  <= '0;
      mis_q      <= 1'b0;
      mis_tag_q  <= '0;
      cerr_q     <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
      pred_q     <= pred_d;
      taken_q    <= taken_d;
      index_q    <= index_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      upd_v_q    <= upd_v_d;
      upd_val_q  <= upd_val_d;
      upd_idx_q  <= upd_idx_d;
      mis_q      <= mis_d;
      mis_tag_q  <= mis_tag_d;
      cerr_q     <= cerr_d;
    end
  end

  assign bus.alloc_ready    = alloc_ready;
  assign bus.alloc_tag      = tail_q;
  assign bus.update_valid   = upd_v_q;
  assign bus.update_value   = upd_val_q;
  assign bus.index_write    = upd_idx_q;
  assign bus.mispredict     = mis_q;
  assign bus.mispredict_tag = mis_tag_q;
  assign bus.commit_err     = cerr_q;
  assign bus.count          = count_q;
endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue; expected values are hand-derived.
module tb_branch_update_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_update_queue_if #(.IDX_W(10), .TAG_W(4)) bus();
  branch_update_queue #(.DEPTH(16), .IDX_W(10), .TAG_W(4)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  task automatic idle();
    bus.alloc_valid = 0; bus.alloc_index = '0; bus.alloc_pred = 0;
    bus.resolve_valid = 0; bus.resolve_tag = '0; bus.resolve_taken = 0;
    bus.commit_valid = 0; bus.flush = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; cyc(); cyc(); rst_n = 1; cyc();
  endtask

  task automatic alloc(input logic [9:0] idx, input logic pred);
    bus.alloc_valid = 1; bus.alloc_index = idx; bus.alloc_pred = pred;
    cyc(); idle();
  endtask

  task automatic resolve(input logic [3:0] tag, input logic taken);
    bus.resolve_valid = 1; bus.resolve_tag = tag; bus.resolve_taken = taken;
    cyc(); idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.alloc_ready); end
    checks++; if (bus.alloc_tag !== 4'd0) begin errors++; $display("FAIL reset_tag got %0d exp 0", bus.alloc_tag); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if ({bus.update_valid, bus.mispredict, bus.commit_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {bus.update_valid, bus.mispredict, bus.commit_err}); end
    checks++; if (bus.index_write !== 10'd0 || bus.update_value !== 1'b0 || bus.mispredict_tag !== 4'd0) begin errors++; $display("FAIL reset_regs got %h/%b/%0d exp 0/0/0", bus.index_write, bus.update_value, bus.mispredict_tag); end
  endtask

  task automatic test_basic();
    do_reset();
    bus.alloc_valid = 1; bus.alloc_index = 10'h2A; bus.alloc_pred = 0;
    checks++; if (bus.alloc_tag !== 4'd0) begin errors++; $display("FAIL basic_tag got %0d exp 0", bus.alloc_tag); end
    cyc(); idle();
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL basic_count1 got %0d exp 1", bus.count); end
    resolve(4'd0, 1'b1);
    checks++; if (bus.mispredict !== 1'b1 || bus.mispredict_tag !== 4'd0) begin errors++; $display("FAIL basic_mis got %b/%0d exp 1/0", bus.mispredict, bus.mispredict_tag); end
    cyc();
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL basic_mis_pulse got %b exp 0", bus.mispredict); end
    bus.commit_valid = 1; cyc(); idle();
    checks++; if (bus.update_valid !== 1'b1 || bus.index_write !== 10'h2A || bus.update_value !== 1'b1) begin errors++; $display("FAIL basic_update got %b/%h/%b exp 1/2a/1", bus.update_valid, bus.index_write, bus.update_value); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL basic_count0 got %0d exp 0", bus.count); end
    cyc();
    checks++; if (bus.update_valid !== 1'b0) begin errors++; $display("FAIL basic_upd_pulse got %b exp 0", bus.update_valid); end
  endtask

  task automatic test_ooo();
    logic [9:0] exp_idx [3] = '{10'h010, 10'h011, 10'h012};
    logic       exp_val [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    alloc(10'h010, 1); alloc(10'h011, 0); alloc(10'h012, 1);
    resolve(4'd2, 1'b0);
    checks++; if (bus.mispredict !== 1'b1 || bus.mispredict_tag !== 4'd2) begin errors++; $display("FAIL ooo_mis2 got %b/%0d exp 1/2", bus.mispredict, bus.mispredict_tag); end
    resolve(4'd0, 1'b1);
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL ooo_mis0 got %b exp 0", bus.mispredict); end
    resolve(4'd1, 1'b1);
    checks++; if (bus.mispredict !== 1'b1 || bus.mispredict_tag !== 4'd1) begin errors++; $display("FAIL ooo_mis1 got %b/%0d exp 1/1", bus.mispredict, bus.mispredict_tag); end
    bus.commit_valid = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (bus.update_valid !== 1'b1 || bus.index_write !== exp_idx[k] || bus.update_value !== exp_val[k]) begin errors++; $display("FAIL ooo_update%0d got %b/%h/%b exp 1/%h/%b", k, bus.update_valid, bus.index_write, bus.update_value, exp_idx[k], exp_val[k]); end
    end
    idle();
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL ooo_count got %0d exp 0", bus.count); end
  endtask

  task automatic test_full_wrap();
    logic [9:0] ei;
    logic       ev;
    do_reset();
    for (int i = 0; i < 16; i++) alloc(10'(10'h100 + i), i[0]);
    checks++; if (bus.alloc_ready !== 1'b0 || bus.count !== 5'd16) begin errors++; $display("FAIL full_state got %b/%0d exp 0/16", bus.alloc_ready, bus.count); end
    alloc(10'h3FF, 1);
    checks++; if (bus.count !== 5'd16 || bus.alloc_tag !== 4'd0) begin errors++; $display("FAIL full_ignore got %0d/%0d exp 16/0", bus.count, bus.alloc_tag); end
    for (int i = 0; i < 16; i++) resolve(4'(i), i[1]);
    // commit plus alloc while full: the alloc must be dropped
    bus.commit_valid = 1; bus.alloc_valid = 1; bus.alloc_index = 10'h1FF; bus.alloc_pred = 0;
    cyc(); idle();
    checks++; if (bus.update_valid !== 1'b1 || bus.index_write !== 10'h100 || bus.update_value !== 1'b0) begin errors++; $display("FAIL wrap_first got %b/%h/%b exp 1/100/0", bus.update_valid, bus.index_write, bus.update_value); end
    checks++; if (bus.count !== 5'd15 || bus.alloc_tag !== 4'd0 || bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL wrap_cnt got %0d/%0d/%b exp 15/0/1", bus.count, bus.alloc_tag, bus.alloc_ready); end
    alloc(10'h1FF, 0);
    checks++; if (bus.count !== 5'd16 || bus.alloc_tag !== 4'd1) begin errors++; $display("FAIL wrap_alloc got %0d/%0d exp 16/1", bus.count, bus.alloc_tag); end
    resolve(4'd0, 1'b1);
    checks++; if (bus.mispredict !== 1'b1 || bus.mispredict_tag !== 4'd0) begin errors++; $display("FAIL wrap_mis got %b/%0d exp 1/0", bus.mispredict, bus.mispredict_tag); end
    bus.commit_valid = 1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      ei = (k < 16) ? 10'(10'h100 + k) : 10'h1FF;
      ev = (k < 16) ? k[1] : 1'b1;
      checks++; if (bus.update_valid !== 1'b1 || bus.index_write !== ei || bus.update_value !== ev) begin errors++; $display("FAIL drain%0d got %b/%h/%b exp 1/%h/%b", k, bus.update_valid, bus.index_write, bus.update_value, ei, ev); end
    end
    idle(); cyc();
    checks++; if (bus.count !== 5'd0 || bus.alloc_ready !== 1'b1 || bus.update_valid !== 1'b0) begin errors++; $display("FAIL drain_end got %0d/%b/%b exp 0/1/0", bus.count, bus.alloc_ready, bus.update_valid); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(10'(10'h030 + i), 1'b0);
    for (int i = 0; i < 3; i++) resolve(4'(i), 1'b0);
    bus.commit_valid = 1; cyc(); cyc(); cyc(); idle();
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL same_pre got %0d exp 1", bus.count); end
    bus.resolve_valid = 1; bus.resolve_tag = 4'd3; bus.resolve_taken = 1; bus.commit_valid = 1;
    cyc(); idle();
    checks++; if (bus.update_valid !== 1'b1 || bus.update_value !== 1'b1 || bus.index_write !== 10'h033) begin errors++; $display("FAIL same_update got %b/%b/%h exp 1/1/033", bus.update_valid, bus.update_value, bus.index_write); end
    checks++; if (bus.commit_err !== 1'b0 || bus.count !== 5'd0) begin errors++; $display("FAIL same_err got %b/%0d exp 0/0", bus.commit_err, bus.count); end
    checks++; if (bus.mispredict !== 1'b1 || bus.mispredict_tag !== 4'd3) begin errors++; $display("FAIL same_mis got %b/%0d exp 1/3", bus.mispredict, bus.mispredict_tag); end
  endtask

  task automatic test_illegal();
    do_reset();
    alloc(10'h055, 1);
    bus.commit_valid = 1; cyc(); idle();
    checks++; if (bus.commit_err !== 1'b1 || bus.update_valid !== 1'b0 || bus.count !== 5'd1) begin errors++; $display("FAIL illegal_unres got %b/%b/%0d exp 1/0/1", bus.commit_err, bus.update_valid, bus.count); end
    cyc();
    checks++; if (bus.commit_err !== 1'b0) begin errors++; $display("FAIL illegal_pulse got %b exp 0", bus.commit_err); end
    resolve(4'd5, 1'b0);
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL illegal_badtag got %b exp 0", bus.mispredict); end
    resolve(4'd0, 1'b0);
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL illegal_res got %b exp 1", bus.mispredict); end
    resolve(4'd0, 1'b1);
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL illegal_reres got %b exp 0", bus.mispredict); end
    bus.commit_valid = 1; cyc(); idle();
    checks++; if (bus.update_value !== 1'b0 || bus.update_valid !== 1'b1) begin errors++; $display("FAIL illegal_keep got %b/%b exp 1/0", bus.update_valid, bus.update_value); end
    bus.commit_valid = 1; cyc(); idle();
    checks++; if (bus.commit_err !== 1'b1 || bus.update_valid !== 1'b0 || bus.count !== 5'd0) begin errors++; $display("FAIL illegal_empty got %b/%b/%0d exp 1/0/0", bus.commit_err, bus.update_valid, bus.count); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(10'(10'h060 + i), 1'b0);
    resolve(4'd0, 1'b1);
    bus.flush = 1; bus.commit_valid = 1; bus.alloc_valid = 1; bus.alloc_index = 10'h3AA;
    bus.resolve_valid = 1; bus.resolve_tag = 4'd1; bus.resolve_taken = 1;
    cyc(); idle();
    checks++; if (bus.update_valid !== 1'b1 || bus.index_write !== 10'h060 || bus.update_value !== 1'b1) begin errors++; $display("FAIL flush_update got %b/%h/%b exp 1/060/1", bus.update_valid, bus.index_write, bus.update_value); end
    checks++; if (bus.count !== 5'd0 || bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 4'd4) begin errors++; $display("FAIL flush_state got %0d/%b/%0d exp 0/1/4", bus.count, bus.alloc_ready, bus.alloc_tag); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL flush_mis got %b exp 0", bus.mispredict); end
    bus.commit_valid = 1; cyc(); idle();
    checks++; if (bus.commit_err !== 1'b1 || bus.update_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b/%b exp 1/0", bus.commit_err, bus.update_valid); end
  endtask

  task automatic test_midreset();
    do_reset();
    alloc(10'h077, 0); alloc(10'h078, 1);
    resolve(4'd0, 1'b1);
    bus.commit_valid = 1;
    @(negedge clk); rst_n = 0; #1;
    checks++; if (bus.count !== 5'd0 || bus.update_valid !== 1'b0 || bus.mispredict !== 1'b0) begin errors++; $display("FAIL midreset got %0d/%b/%b exp 0/0/0", bus.count, bus.update_valid, bus.mispredict); end
    idle(); cyc(); rst_n = 1; cyc();
    checks++; if (bus.update_valid !== 1'b0 || bus.alloc_tag !== 4'd0) begin errors++; $display("FAIL midreset_after got %b/%0d exp 0/0", bus.update_valid, bus.alloc_tag); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    test_reset();
    test_basic();
    test_ooo();
    test_full_wrap();
    test_same_cycle();
    test_illegal();
    test_flush();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
- Commit-side counterpart of the fetch-stage branch prediction buffer.
- At fetch, every predicted branch allocates an entry holding its BPB index and predicted direction. Entries resolve out of order at execute. They retire in order at commit.
- Retirement drives the BPB write port (update_valid / update_value / index_write), so each 2-bit FSM trains exactly once per committed branch.
- Mispredictions detected at resolve are flagged to the front end.

Parameters:
- DEPTH, 16, number of in-flight branch entries; power of two, 2 to 64
- IDX_W, 10, BPB index width; must match the BPB index ports
- TAG_W, 4, entry tag width; equals log2(DEPTH)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- alloc_valid  input  1  fetch allocates a branch entry this cycle
- alloc_index  input  IDX_W  BPB index used for the prediction
- alloc_pred  input  1  predicted direction (1 = taken)
- alloc_ready  output  1  queue not full; combinational from registered count
- alloc_tag  output  TAG_W  tag assigned to the entry (current tail pointer)
- resolve_valid  input  1  execute reports a branch outcome
- resolve_tag  input  TAG_W  entry being resolved
- resolve_taken  input  1  actual direction
- commit_valid  input  1  ROB retires the oldest branch
- flush  input  1  discard all in-flight entries
- update_valid  output  1  BPB write enable (registered)
- update_value  output  1  actual direction written to BPB (registered)
- index_write  output  IDX_W  BPB index to train (registered)
- mispredict  output  1  one-cycle pulse, resolved direction differs from prediction
- mispredict_tag  output  TAG_W  tag of the mispredicted entry
- commit_err  output  1  one-cycle pulse, illegal commit attempt
- count  output  TAG_W+1  number of valid entries

Behaviour:
- Storage, per entry:
  - valid, resolved, pred, taken, index
  - head pointer, tail pointer (TAG_W bits each, wrap modulo DEPTH)
  - count register
- Reset (reset low, asynchronous):
  - all valid/resolved bits cleared; head = tail = count = 0
  - update_valid = 0, update_value = 0, index_write = 0
  - mispredict = 0, mispredict_tag = 0, commit_err = 0
  - alloc_ready = 1, alloc_tag = 0
  - Reset asserted mid-operation discards all entries with no BPB write.
- Allocate:
  - Occurs when alloc_valid and alloc_ready.
  - Entry[tail] is written with valid = 1, resolved = 0, pred, index; then tail++.
  - alloc_valid while full is ignored: no state change, no error.
  - A commit in the same cycle does not make a full queue ready that cycle.
- Resolve:
  - Occurs when resolve_valid and entry[resolve_tag].valid and not resolved.
  - Sets resolved = 1 and taken = resolve_taken.
  - Next cycle: mispredict = (resolve_taken != pred) and mispredict_tag = resolve_tag.
  - Resolve to an invalid or already-resolved tag is ignored.
- Commit:
  - Occurs when commit_valid and entry[head] is valid and either already resolved or resolved in this same cycle (resolve_tag == head).
  - In the same-cycle case, resolve_taken is bypassed into the update.
  - Next cycle: update_valid = 1, update_value = taken, index_write = entry index. Latency is 1 cycle.
  - The entry is invalidated and head++.
  - commit_valid when the queue is empty, or the head is unresolved: no dequeue, no update, commit_err pulses next cycle.
- Count: +1 on allocate, -1 on commit; both in one cycle leaves it unchanged. Never exceeds DEPTH.
- Flush:
  - A commit in the flush cycle is processed first; its BPB update is still emitted.
  - Then all entries are cleared, head = tail, count = 0.
  - An allocate in the flush cycle is dropped.
  - A resolve in the flush cycle produces no mispredict.
- update_valid, mispredict and commit_err are single-cycle pulses; each returns to 0 unless re-triggered.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble.

Test Plan:
- Basic train: after reset, alloc (index=0x2A, pred=0) gives tag 0; resolve tag 0 taken=1 -> mispredict=1, tag 0 the next cycle; commit -> next cycle update_valid=1, index_write=0x2A, update_value=1, count=0.
- Out-of-order resolve: alloc tags 0, 1, 2; resolve 2, 0, 1; three commits -> updates emitted in tag order 0, 1, 2, each carrying its own outcome.
- Full and wrap: 16 allocs -> alloc_ready=0, count=16; a 17th alloc is ignored; commit one and alloc -> new tag is 0 (tail wrapped); drain all 16 correctly.
- Same-cycle resolve+commit on head tag 3 with taken=1 -> update_value=1 the next cycle, no commit_err.
- Illegal commit: commit with head unresolved -> commit_err=1, no update_valid, count unchanged; commit on empty queue -> commit_err=1.
- Flush with concurrent commit and alloc (4 entries, head resolved) -> one update emitted, alloc dropped, count=0, alloc_ready=1.
